// File: rtl/pf_pkg.sv
// Shared widths, status bit positions and FSM state type for the float
// normalise/round pipeline.
package pf_pkg;

    localparam int unsigned EXP_W     = 6;
    localparam int unsigned FRAC_W    = 25;
    localparam int unsigned MANT_IN_W = 29;
    localparam int unsigned BIAS      = 31;
    localparam int unsigned EXP_MAX   = 63;

    // Bit positions within the [0:3] status word.
    localparam int unsigned ST_EXACT     = 0;
    localparam int unsigned ST_OVERFLOW  = 1;
    localparam int unsigned ST_UNDERFLOW = 2;
    localparam int unsigned ST_INEXACT   = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StNorm  = 2'd1,
        StRound = 2'd2,
        StDone  = 2'd3
    } pf_state_e;

endpackage

// File: rtl/pf_round_rne.sv
// Round-to-nearest-even increment of a hidden-one significand, reporting
// carry-out and renormalising the fraction when the increment overflows.
module pf_round_rne
    import pf_pkg::*;
(
    input  logic [FRAC_W:0]   sig_i,
    input  logic              guard_i,
    input  logic              sticky_i,
    output logic [FRAC_W-1:0] frac_o,
    output logic              carry_o,
    output logic              inexact_o
);

    logic              inc;
    logic [FRAC_W+1:0] sum;

    always_comb begin
        inc       = guard_i & (sticky_i | sig_i[0]);
        sum       = {1'b0, sig_i} + {{(FRAC_W + 1){1'b0}}, inc};
        carry_o   = sum[FRAC_W+1];
        // On carry the value is exactly 2.0, so the shifted fraction is all zero.
        frac_o    = carry_o ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
        inexact_o = guard_i | sticky_i;
    end

endmodule

// File: rtl/pf_normalize_round.sv
// Multi-cycle normaliser and RNE rounder that packs a raw adder result into
// sign/exponent/fraction with exact/overflow/underflow/inexact flags.
module pf_normalize_round
    import pf_pkg::*;
(
    input  logic                 clock_100kHz,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [MANT_IN_W-1:0] in_mant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:31]          data_out,
    output logic [0:3]           status_out
);

    localparam logic [EXP_W:0] ExpOvf = (EXP_W + 1)'(EXP_MAX);
    localparam logic [EXP_W:0] ExpOne = (EXP_W + 1)'(1);

    pf_state_e state_q, state_d;

    logic                 sign_q, sign_d;
    logic [EXP_W:0]       exp_q, exp_d;
    logic [MANT_IN_W-1:0] mant_q, mant_d;
    logic [0:31]          data_q, data_d;
    logic [0:3]           status_q, status_d;

    logic [FRAC_W-1:0]    rne_frac;
    logic                 rne_carry;
    logic                 rne_inexact;
    logic [EXP_W:0]       exp_r;

    pf_round_rne u_round (
        .sig_i     (mant_q[MANT_IN_W-2:2]),
        .guard_i   (mant_q[1]),
        .sticky_i  (mant_q[0]),
        .frac_o    (rne_frac),
        .carry_o   (rne_carry),
        .inexact_o (rne_inexact)
    );

    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        data_d   = data_q;
        status_d = status_q;
        // Exponent is one bit wider so a carry out of 62/63 is not lost.
        exp_r    = exp_q + {{EXP_W{1'b0}}, rne_carry};

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exp};
                    mant_d  = in_mant;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (mant_q == '0) begin
                    data_d             = '0;
                    status_d           = '0;
                    status_d[ST_EXACT] = 1'b1;
                    state_d            = StDone;
                end else if (mant_q[MANT_IN_W-1]) begin
                    mant_d  = {1'b0, mant_q[MANT_IN_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + ExpOne;
                    state_d = StRound;
                end else if (mant_q[MANT_IN_W-2]) begin
                    state_d = StRound;
                end else if (exp_q == ExpOne) begin
                    data_d                 = {sign_q, 31'b0};
                    status_d               = '0;
                    status_d[ST_UNDERFLOW] = 1'b1;
                    status_d[ST_INEXACT]   = 1'b1;
                    state_d                = StDone;
                end else begin
                    mant_d = {mant_q[MANT_IN_W-2:0], 1'b0};
                    exp_d  = exp_q - ExpOne;
                end
            end
            StRound: begin
                status_d = '0;
                if (exp_r >= ExpOvf) begin
                    data_d                = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    status_d[ST_OVERFLOW] = 1'b1;
                    status_d[ST_INEXACT]  = 1'b1;
                end else begin
                    data_d               = {sign_q, exp_r[EXP_W-1:0], rne_frac};
                    status_d[ST_EXACT]   = ~rne_inexact;
                    status_d[ST_INEXACT] = rne_inexact;
                end
                exp_d   = exp_r;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StDone);
        data_out   = data_q;
        status_out = status_q;
    end

endmodule

// File: doc/pf_normalize_round.md
PF_NORMALIZE_ROUND -- requirements
Module: pf_normalize_round

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset:
- clock_100kHz  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
REQ-002 The upstream (raw adder result) ports SHALL be:
- in_valid  in  1  raw result present
- in_ready  out  1  block can accept
- in_sign  in  1  result sign
- in_exp  in  6  biased exponent of the aligned operands (bias 31)
- in_mant  in  29  bit28 carry, bit27 hidden one, bits26:2 fraction, bit1 guard, bit0 sticky
REQ-003 The downstream ports SHALL be:
- out_valid  out  1  packed result present
- out_ready  in  1  consumer takes result
- data_out  out  [0:31]  [0] sign, [1:6] biased exponent, [7:31] 25-bit fraction
- status_out  out  [0:3]  [0] exact, [1] overflow, [2] underflow, [3] inexact

Function
REQ-004 The FSM SHALL have states IDLE, NORM, ROUND and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-005 IDLE: on in_valid&in_ready, the block SHALL capture sign/exp/mant and go to NORM; it SHALL NOT accept in any other state.
REQ-006 NORM, priority order:
- mant==0 -> DONE, data_out=0x00000000 (sign forced 0), status exact
- bit28=1 -> shift right 1, OR dropped bit into sticky, exp+1, go to ROUND
- bit27=1 -> go to ROUND
- else, if exp==1 -> DONE with underflow
- else shift left 1 (zero in), exp-1, stay in NORM
REQ-007 Left normalisation SHALL shift one bit per cycle; the worst case is 27 NORM cycles.
REQ-008 ROUND SHALL apply round-to-nearest-even: increment the fraction iff guard & (sticky | fraction LSB).
REQ-009 If the increment carries into bit28, ROUND SHALL shift right 1 and increment exp in the same cycle.
REQ-010 inexact SHALL equal guard|sticky, evaluated before the increment.
REQ-011 Overflow: if the exp after ROUND is 63, the result SHALL be {sign, 6'b111111, 25'b0}, and overflow=1 and inexact=1.
REQ-012 Underflow result SHALL be {sign, 31'b0}, with underflow=1 and inexact=1.
REQ-013 exact SHALL be 1 iff overflow, underflow and inexact are all 0; exactly one of exact or inexact SHALL be 1 for every result.
REQ-014 Latency, counted from the accept edge until out_valid is visible:
- normalised or carry input: 3 cycles
- plus 1 cycle per left shift
- zero input: 2 cycles
REQ-015 DONE SHALL hold data_out, status_out and out_valid stable until out_ready=1; on out_ready it SHALL go to IDLE, with in_ready rising the next cycle. There is no same-cycle turnaround.
REQ-016 data_out and status_out SHALL be registered; they SHALL keep their last value outside DONE.

Reset
REQ-017 When reset=1 at a clock edge, the FSM SHALL go to IDLE and all registers SHALL clear to 0:
- data_out=0, status_out=0, out_valid=0
- in_ready=1 from the first cycle after reset deasserts
REQ-018 Reset during NORM, ROUND or DONE SHALL discard the in-flight operation without emitting a result.

Structure
REQ-019 The package pf_pkg SHALL hold:
- the widths: EXP_W=6, FRAC_W=25, MANT_IN_W=29
- BIAS=31 and EXP_MAX=63
- the status bit indices
- the state enum, shared with the adder stage
REQ-020 The combinational RNE increment with carry-out SHALL be the sub-module pf_round_rne; the FSM, shifter and packing logic SHALL stay in pf_normalize_round.

Verification
REQ-021 The bench SHALL cover at least the following scenarios:
- Normalised input: exp=31, mant=bit27 only -> data_out=0x3E000000, status=4'b1000, out_valid 3 cycles after accept.
- Carry input: exp=31, mant=bit28 only -> 0x40000000, status=4'b1000, latency 3.
- Three left shifts: exp=31, mant=bit24 only -> 0x38000000, status=4'b1000, latency 6.
- RNE tie: exp=31, mant=bit27 | fraction LSB(bit2) | guard -> 0x3E000002, status=4'b0001.
- Overflow: exp=62, mant=bit28 only -> 0x7E000000, status=4'b0101.
- Underflow and control:
  - sign=1, exp=1, mant=bit26 only -> 0x80000000, status=4'b0011.
  - With out_ready held low 5 cycles, outputs stay stable.
  - Reset asserted in NORM -> no out_valid, in_ready=1 the next cycle.
